motoro3_line_step_sequencer: RTL

MOTORO3_LINE_STEP_SEQUENCER -- requirements
Module: motoro3_line_step_sequencer

---
 rtl/motoro3_pkg.sv | 27 ++
 rtl/motoro3_pwm_period_cnt.sv | 78 +++++++
 rtl/motoro3_line_step_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/motoro3_pkg.sv
// ---------------------------------------------------------------------------
// motoro3_pkg
// Shared definitions for the motoro3 line step sequencer:
//   - m3_state_e : sequencer FSM state encoding (IDLE, LOAD, RUN, STOP)
//   - STEP_MAX   : largest number of line steps per cycle (16)
//   - step_count : step-split code -> steps per cycle (2 << code)
// ---------------------------------------------------------------------------
package motoro3_pkg;

   localparam int unsigned STEP_MAX = 16;
   localparam int unsigned STEP_W   = $clog2(STEP_MAX);
   localparam int unsigned SPD_W    = 25;
   localparam int unsigned PWM_W    = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_STOP = 2'd3
   } m3_state_e;

   // One bit wider than lcStep so the 16-step case is representable.
   function automatic logic [STEP_W:0] step_count(input logic [1:0] split);
      return (STEP_W + 1)'(2) << split;
   endfunction

endpackage

// File: rtl/motoro3_pwm_period_cnt.sv
// ---------------------------------------------------------------------------
// motoro3_pwm_period_cnt
// PWM period counter with shadowed period/high lengths and the output compare.
// Shadows reload only at the period end so a length change never cuts a
// period short. A zero period length holds the counter at 0, keeps the
// output low and re-samples the lengths every cycle until they become nonzero.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   load_i          : LOAD state - latch lengths, clear counter
//   active_i        : RUN or STOP state - counter runs, output enabled
//   pl_len_i        : period length (clk cycles) for the current step
//   sl_len_i        : high length (clk cycles) for the current step
//   pwm_o           : PWM drive
//   period_end_o    : last cycle of the current period (or zero-length period)
// ---------------------------------------------------------------------------
module motoro3_pwm_period_cnt
   import motoro3_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             active_i,
   input  logic [PWM_W-1:0] pl_len_i,
   input  logic [PWM_W-1:0] sl_len_i,
   output logic             pwm_o,
   output logic             period_end_o
);

   logic [PWM_W-1:0] cnt_q, cnt_d;
   logic [PWM_W-1:0] pl_q,  pl_d;
   logic [PWM_W-1:0] sl_q,  sl_d;
   logic             period_end;

   assign period_end = active_i && ((pl_q == '0) || (cnt_q == pl_q - PWM_W'(1)));

   // NOTE: every variable gets its default at the top of the block, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      pl_d  = pl_q;
      sl_d  = sl_q;
      if (load_i) begin
         cnt_d = '0;
         pl_d  = pl_len_i;
         sl_d  = sl_len_i;
      end else if (active_i) begin
         if (period_end) begin
            // Wrap; lengths sampled here still belong to the step shown on
            // lcStep this cycle, even if the step advances on the same edge.
            cnt_d = '0;
            pl_d  = pl_len_i;
            sl_d  = sl_len_i;
         end else begin
            cnt_d = cnt_q + PWM_W'(1);
         end
      end
   end

   // NOTE: state registers use non-blocking assignments only, so all flops
   // sample the pre-edge values regardless of block ordering. The shadows are
   // ordinary flops (not a RAM), so they are cleared by reset like the rest.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         pl_q  <= '0;
         sl_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         pl_q  <= pl_d;
         sl_q  <= sl_d;
      end
   end

   // sl >= pl naturally gives a constant high since cnt never reaches pl.
   assign pwm_o        = active_i && (pl_q != '0) && (cnt_q < sl_q);
   assign period_end_o = period_end;

endmodule

// File: rtl/motoro3_line_step_sequencer.sv
// ---------------------------------------------------------------------------
// motoro3_line_step_sequencer
// Steps a line through 2/4/8/16 positions at a programmable rate while
// driving a PWM whose period/high lengths come from an external calculator
// indexed by lcStep. FSM: IDLE -> LOAD -> RUN -> STOP -> IDLE/RUN.
// STOP finishes the current PWM period before going idle, or resumes RUN at
// that period end if m3r_enable has come back.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   m3r_enable             : run request
//   m3r_stepCNT_speedSET   : clk cycles per step (0 freezes lcStep)
//   m3r_stepSplitMax       : steps per cycle = 2 << code
//   m3r_stepDir            : 1 = lcStep counts down (MOTORO3_STEP_DIR_EN only)
//   plLen, slLen           : PWM period / high length for the current step
//   lcStep                 : current step index
//   pwmOut                 : line PWM drive
//   stepPulse              : one-cycle strobe in the cycle lcStep advances
//   busy                   : high whenever the FSM is not IDLE
// Build option: define MOTORO3_STEP_DIR_EN to add the m3r_stepDir input.
// ---------------------------------------------------------------------------
module motoro3_line_step_sequencer
   import motoro3_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              m3r_enable,
   input  logic [SPD_W-1:0]  m3r_stepCNT_speedSET,
   input  logic [1:0]        m3r_stepSplitMax,
`ifdef MOTORO3_STEP_DIR_EN
   input  logic              m3r_stepDir,
`endif
   input  logic [PWM_W-1:0]  plLen,
   input  logic [PWM_W-1:0]  slLen,
   output logic [STEP_W-1:0] lcStep,
   output logic              pwmOut,
   output logic              stepPulse,
   output logic              busy
);

   m3_state_e          state_q, state_d;
   logic [SPD_W-1:0]   step_cnt_q, step_cnt_d;
   logic [STEP_W-1:0]  lc_q, lc_d;
   logic               period_end;
   logic               speed_nz;
   logic               step_adv;
   logic               step_down;
   logic [STEP_W:0]    lc_max;
   logic [STEP_W-1:0]  lc_inc, lc_dec;

`ifdef MOTORO3_STEP_DIR_EN
   assign step_down = m3r_stepDir;
`else
   assign step_down = 1'b0;
`endif

   // ---------------- PWM period counter ----------------
   motoro3_pwm_period_cnt u_pwm (
      .clk          (clk),
      .rst          (rst),
      .load_i       (state_q == ST_LOAD),
      .active_i     ((state_q == ST_RUN) || (state_q == ST_STOP)),
      .pl_len_i     (plLen),
      .sl_len_i     (slLen),
      .pwm_o        (pwmOut),
      .period_end_o (period_end)
   );

   // ---------------- FSM ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (m3r_enable)  state_d = ST_LOAD;
         ST_LOAD:                  state_d = ST_RUN;
         ST_RUN:  if (!m3r_enable) state_d = ST_STOP;
         ST_STOP: if (period_end)  state_d = m3r_enable ? ST_RUN : ST_IDLE;
         default:                  state_d = ST_IDLE;
      endcase
   end

   // ---------------- step counter / lcStep ----------------
   assign speed_nz = (m3r_stepCNT_speedSET != '0);
   // ">=" rather than "==" so a count already past a lowered terminal value
   // still advances instead of running the full 25-bit range.
   assign step_adv = (state_q == ST_RUN) && speed_nz &&
                     (step_cnt_q >= m3r_stepCNT_speedSET - SPD_W'(1));

   // lcStep above the current maximum (after a split change) wraps to the
   // start of the sequence on the next advance.
   assign lc_max = step_count(m3r_stepSplitMax) - (STEP_W + 1)'(1);
   assign lc_inc = ({1'b0, lc_q} >= lc_max) ? '0 : lc_q + STEP_W'(1);
   assign lc_dec = ((lc_q == '0) || ({1'b0, lc_q} > lc_max)) ?
                   lc_max[STEP_W-1:0] : lc_q - STEP_W'(1);

   always_comb begin
      step_cnt_d = step_cnt_q;
      lc_d       = lc_q;
      if (state_q == ST_LOAD) begin
         step_cnt_d = '0;
      end else if ((state_q == ST_RUN) && speed_nz) begin
         if (step_adv) begin
            step_cnt_d = '0;
            lc_d       = step_down ? lc_dec : lc_inc;
         end else begin
            step_cnt_d = step_cnt_q + SPD_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         step_cnt_q <= '0;
         lc_q       <= '0;
      end else begin
         state_q    <= state_d;
         step_cnt_q <= step_cnt_d;
         lc_q       <= lc_d;
      end
   end

   assign lcStep    = lc_q;
   assign stepPulse = step_adv;
   assign busy      = (state_q != ST_IDLE);

endmodule
